// File: rtl/led_matrix_pkg.sv
// Shared types and constants for the HUB75 BCM scan driver.
package led_matrix_pkg;

  // Scan sequencer states; the encoding is visible on the debug port.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SET,
    ST_CLK_HI,
    ST_CLK_LO,
    ST_WAIT_TMR,
    ST_LATCH,
    ST_UNBLANK
  } scan_state_e;

  // Pixel word = {upperR, upperG, upperB, lowerR, lowerG, lowerB}, each
  // field COLOR_BITS wide; these are field indices counted from the LSB.
  localparam int NUM_FIELDS  = 6;
  localparam int FLD_LOWER_B = 0;
  localparam int FLD_LOWER_G = 1;
  localparam int FLD_LOWER_R = 2;
  localparam int FLD_UPPER_B = 3;
  localparam int FLD_UPPER_G = 4;
  localparam int FLD_UPPER_R = 5;

  // Display time of bit-plane p: binary weight applied to the base period.
  function automatic int plane_ticks(input int base, input int p);
    return base << p;
  endfunction

endpackage

// File: rtl/led_matrix_bcm_driver_timer.sv
// Saturating down-counter that times how long a latched plane stays lit.
module bcm_row_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load wins; otherwise count down and stick at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Flag is raised one cycle early (count of 1) so that the sequencer's
  // registered blank goes high exactly N cycles after a load of N.
  assign zero_o = (cnt_q <= W'(1));

endmodule

// File: rtl/led_matrix_bcm_driver.sv
// HUB75 scan driver: fetches pixel words, shifts one bit-plane per row,
// latches it and keeps it lit for its binary weight while the next plane
// is shifted in behind it.
module led_matrix_bcm_driver
  import led_matrix_pkg::*;
#(
  parameter int COLS       = 32,
  parameter int SCAN_ROWS  = 16,
  parameter int COLOR_BITS = 2,
  parameter int BASE_TICKS = 64,
  localparam int RW = (SCAN_ROWS > 1) ? $clog2(SCAN_ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int PW = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1,
  localparam int AW = 1 + RW + CW,
  localparam int DW = 6 * COLOR_BITS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          useSecondaryBuffer,
  output logic          fb_rd_en,
  output logic [AW-1:0] fb_rd_addr,
  input  logic [DW-1:0] fb_rd_data,
  output logic [RW-1:0] matrix_rowDecoder,
  output logic          matrix_pixelClk,
  output logic [2:0]    matrix_columnPixelsUpper,
  output logic [2:0]    matrix_columnPixelsLower,
  output logic          matrix_columnLatch,
  output logic          matrix_blank,
  output logic          active_buffer,
  output logic          frame_done,
  output scan_state_e   dbg_state
);

  localparam int TW = $clog2(BASE_TICKS << (COLOR_BITS - 1)) + 1;

  // Frame-buffer read: fb_rd_addr is valid while fb_rd_en is high (the FETCH
  // cycle); the RAM returns fb_rd_data one cycle later (the SET cycle). There
  // is no back-pressure.
  scan_state_e     state_q;
  logic [RW-1:0]   row_q, row_d;
  logic [PW-1:0]   plane_q, plane_d;
  logic [CW-1:0]   col_q, col_d;
  logic            col_last, plane_last, row_last, frame_wrap;
  logic            fb_rd_en_q, pclk_q, latch_q, blank_q, active_buf_q, frame_done_q;
  logic [AW-1:0]   fb_rd_addr_q;
  logic [RW-1:0]   row_dec_q;
  logic [2:0]      upper_q, lower_q;
  logic [COLOR_BITS-1:0] chan [NUM_FIELDS];
  logic            timer_load, timer_zero;
  logic [TW-1:0]   timer_val;

  // Split the pixel word into its six colour channels.
  always_comb begin
    for (int f = 0; f < NUM_FIELDS; f++) begin
      chan[f] = fb_rd_data[f*COLOR_BITS +: COLOR_BITS];
    end
  end

  // Scan position advance; wraps use explicit compares so non-power-of-2
  // geometries work.
  always_comb begin
    col_last   = (col_q == CW'(COLS - 1));
    plane_last = (plane_q == PW'(COLOR_BITS - 1));
    row_last   = (row_q == RW'(SCAN_ROWS - 1));
    col_d      = col_last ? '0 : col_q + 1'b1;
    plane_d    = plane_last ? '0 : plane_q + 1'b1;
    row_d      = plane_last ? (row_last ? '0 : row_q + 1'b1) : row_q;
    // In UNBLANK the position has already advanced, so 0/0 means a frame ended.
    frame_wrap = (row_q == '0) && (plane_q == '0);
  end

  // The plane just latched sets how long it stays lit; loaded on the
  // LATCH->UNBLANK edge so the count starts with the first unblanked cycle.
  assign timer_load = (state_q == ST_LATCH);
  assign timer_val  = TW'(plane_ticks(BASE_TICKS, int'(plane_q)));

  bcm_row_timer #(.W(TW)) u_timer (
    .clk_i      (clk),
    .rst_ni     (rst),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .zero_o     (timer_zero)
  );

  // Sequencer; outputs are registered alongside the state they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      row_q        <= '0;
      plane_q      <= '0;
      col_q        <= '0;
      fb_rd_en_q   <= 1'b0;
      fb_rd_addr_q <= '0;
      row_dec_q    <= '0;
      pclk_q       <= 1'b0;
      upper_q      <= '0;
      lower_q      <= '0;
      latch_q      <= 1'b0;
      blank_q      <= 1'b1;
      active_buf_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      fb_rd_en_q   <= 1'b0;
      pclk_q       <= 1'b0;
      latch_q      <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // The last plane of the previous frame finishes its weight first.
          if (timer_zero) blank_q <= 1'b1;
          if (enable) begin
            active_buf_q <= useSecondaryBuffer;
            fb_rd_en_q   <= 1'b1;
            fb_rd_addr_q <= {useSecondaryBuffer, row_q, col_q};
            state_q      <= ST_FETCH;
          end
        end
        ST_FETCH: state_q <= ST_SET;
        ST_SET: begin
          upper_q <= {chan[FLD_UPPER_R][plane_q], chan[FLD_UPPER_G][plane_q],
                      chan[FLD_UPPER_B][plane_q]};
          lower_q <= {chan[FLD_LOWER_R][plane_q], chan[FLD_LOWER_G][plane_q],
                      chan[FLD_LOWER_B][plane_q]};
          pclk_q  <= 1'b1;
          state_q <= ST_CLK_HI;
        end
        ST_CLK_HI: state_q <= ST_CLK_LO;
        ST_CLK_LO: begin
          col_q <= col_d;
          if (col_last) begin
            state_q <= ST_WAIT_TMR;
          end else begin
            fb_rd_en_q   <= 1'b1;
            fb_rd_addr_q <= {active_buf_q, row_q, col_d};
            state_q      <= ST_FETCH;
          end
        end
        ST_WAIT_TMR: begin
          if (timer_zero) begin
            blank_q   <= 1'b1;
            latch_q   <= 1'b1;
            row_dec_q <= row_q;
            state_q   <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          blank_q <= 1'b0;
          plane_q <= plane_d;
          row_q   <= row_d;
          state_q <= ST_UNBLANK;
        end
        ST_UNBLANK: begin
          if (frame_wrap) begin
            frame_done_q <= 1'b1;
            if (enable) begin
              active_buf_q <= useSecondaryBuffer;
              fb_rd_en_q   <= 1'b1;
              fb_rd_addr_q <= {useSecondaryBuffer, row_q, col_q};
              state_q      <= ST_FETCH;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            fb_rd_en_q   <= 1'b1;
            fb_rd_addr_q <= {active_buf_q, row_q, col_q};
            state_q      <= ST_FETCH;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign fb_rd_en                 = fb_rd_en_q;
  assign fb_rd_addr               = fb_rd_addr_q;
  assign matrix_rowDecoder        = row_dec_q;
  assign matrix_pixelClk          = pclk_q;
  assign matrix_columnPixelsUpper = upper_q;
  assign matrix_columnPixelsLower = lower_q;
  assign matrix_columnLatch       = latch_q;
  assign matrix_blank             = blank_q;
  assign active_buffer            = active_buf_q;
  assign frame_done               = frame_done_q;
  assign dbg_state                = state_q;

endmodule

// File: tb/tb_led_matrix_bcm_driver.sv
// Bench for led_matrix_bcm_driver: 4 columns, 2 scan rows, 2 bit-planes,
// base period 32.
module tb_led_matrix_bcm_driver;
  import led_matrix_pkg::*;

  localparam int COLS = 4, SCAN_ROWS = 2, COLOR_BITS = 2, BASE_TICKS = 32;
  localparam int AW = 4, RW = 1, DW = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic use_sec = 1'b0;
  always #5 clk = ~clk;

  logic          fb_rd_en;
  logic [AW-1:0] fb_rd_addr;
  logic [DW-1:0] fb_rd_data = '0;
  logic [RW-1:0] row_dec;
  logic          pclk, col_latch, blank, active_buf, frame_done;
  logic [2:0]    px_upper, px_lower;
  scan_state_e   dbg_state;

  led_matrix_bcm_driver #(
    .COLS(COLS), .SCAN_ROWS(SCAN_ROWS), .COLOR_BITS(COLOR_BITS), .BASE_TICKS(BASE_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .useSecondaryBuffer(use_sec),
    .fb_rd_en(fb_rd_en), .fb_rd_addr(fb_rd_addr), .fb_rd_data(fb_rd_data),
    .matrix_rowDecoder(row_dec), .matrix_pixelClk(pclk),
    .matrix_columnPixelsUpper(px_upper), .matrix_columnPixelsLower(px_lower),
    .matrix_columnLatch(col_latch), .matrix_blank(blank),
    .active_buffer(active_buf), .frame_done(frame_done), .dbg_state(dbg_state)
  );

  // Frame-buffer RAM with one cycle of read latency. Address {buf,row,col}.
  logic [DW-1:0] mem [16];
  initial begin
    mem[0]  = 12'h6C6; mem[1]  = 12'h9A3; mem[2]  = 12'h35C; mem[3]  = 12'hF0F;
    mem[4]  = 12'h1E2; mem[5]  = 12'hC3A; mem[6]  = 12'h7B5; mem[7]  = 12'h48D;
    mem[8]  = 12'hE71; mem[9]  = 12'h2D6; mem[10] = 12'hB19; mem[11] = 12'h0F0;
    mem[12] = 12'h5AE; mem[13] = 12'hD24; mem[14] = 12'h863; mem[15] = 12'h3C9;
  end
  always @(posedge clk) if (fb_rd_en) fb_rd_data <= mem[fb_rd_addr];

  // ---------------- scoreboard ----------------
  logic [AW-1:0] exp_addr_q [$];
  logic [5:0]    exp_pix_q  [$];
  logic [RW-1:0] exp_row_q  [$];
  int            exp_lit_q  [$];
  int n_checks = 0, n_fail = 0;
  int frames_seen = 0, pix_seen = 0, total_latches = 0;
  bit first_pix = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic report_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event with nothing expected at %0t", name, $time);
  endtask

  // Pixel word layout {UR,UG,UB,LR,LG,LB}, two bits each; take bit p of each.
  function automatic logic [5:0] exp_pix(input logic [AW-1:0] a, input int p);
    logic [DW-1:0] w;
    w = mem[a];
    return {w[10+p], w[8+p], w[6+p], w[4+p], w[2+p], w[p]};
  endfunction

  // Expected traffic of one whole frame read from buffer b.
  task automatic push_frame(input logic b);
    logic [AW-1:0] a;
    for (int r = 0; r < SCAN_ROWS; r++) begin
      for (int p = 0; p < COLOR_BITS; p++) begin
        for (int c = 0; c < COLS; c++) begin
          a = {b, 1'(r), 2'(c)};
          exp_addr_q.push_back(a);
          exp_pix_q.push_back(exp_pix(a, p));
        end
        exp_row_q.push_back(1'(r));
        exp_lit_q.push_back(BASE_TICKS << p);
      end
    end
  endtask

  task automatic clear_queues();
    exp_addr_q.delete(); exp_pix_q.delete(); exp_row_q.delete(); exp_lit_q.delete();
  endtask

  // ---------------- monitor ----------------
  logic pclk_prev = 1'b0, blank_prev = 1'b1;
  int lit_cnt = 0, pclk_cnt = 0, latch_cnt = 0;
  always @(negedge clk) begin
    if (!rst) begin
      pclk_prev = 1'b0; blank_prev = 1'b1; lit_cnt = 0; pclk_cnt = 0; latch_cnt = 0;
    end else begin
      if (fb_rd_en) begin
        if (exp_addr_q.size() == 0) report_fail("unexpected_fb_read");
        else begin
          logic [AW-1:0] ea;
          ea = exp_addr_q.pop_front();
          check("fb_rd_addr", 32'(fb_rd_addr), 32'(ea));
          check("active_buffer", 32'(active_buf), 32'(ea[AW-1]));
        end
      end
      if (pclk && !pclk_prev) begin
        pclk_cnt++; pix_seen++;
        if (exp_pix_q.size() == 0) report_fail("unexpected_pixel_clk");
        else check("pixels", 32'({px_upper, px_lower}), 32'(exp_pix_q.pop_front()));
        if (first_pix) begin
          check("first_upper_plane0", 32'(px_upper), 32'(3'b101));
          first_pix = 1'b0;
        end
      end
      if (col_latch) begin
        check("pclk_per_latch", pclk_cnt, COLS);
        pclk_cnt = 0; latch_cnt++; total_latches++;
        if (exp_row_q.size() == 0) report_fail("unexpected_latch");
        else check("row_decoder", 32'(row_dec), 32'(exp_row_q.pop_front()));
      end
      if (frame_done) begin
        check("latches_per_frame", latch_cnt, SCAN_ROWS * COLOR_BITS);
        latch_cnt = 0; frames_seen++;
      end
      if (!blank && blank_prev) lit_cnt = 1;
      else if (!blank) lit_cnt++;
      if (blank && !blank_prev) begin
        if (exp_lit_q.size() == 0) report_fail("unexpected_lit_period");
        else check("lit_cycles", lit_cnt, exp_lit_q.pop_front());
      end
      pclk_prev = pclk; blank_prev = blank;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_frames(input int n);
    int budget;
    budget = 3000;
    while (frames_seen < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("frame_wait_timeout", 32'(frames_seen >= n), 32'd1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_blank"}, 32'(blank), 32'd1);
    check({tag, "_state_idle"}, 32'(dbg_state), 32'(ST_IDLE));
    check({tag, "_no_read"}, 32'(fb_rd_en), 32'd0);
    check({tag, "_addr_q_empty"}, exp_addr_q.size(), 0);
    check({tag, "_pix_q_empty"}, exp_pix_q.size(), 0);
    check({tag, "_row_q_empty"}, exp_row_q.size(), 0);
    check({tag, "_lit_q_empty"}, exp_lit_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int budget;
    // Reset values while held.
    wait_cycles(3);
    check("rst_blank", 32'(blank), 32'd1);
    check("rst_fb_rd_en", 32'(fb_rd_en), 32'd0);
    check("rst_fb_rd_addr", 32'(fb_rd_addr), 32'd0);
    check("rst_row_dec", 32'(row_dec), 32'd0);
    check("rst_pixel_clk", 32'(pclk), 32'd0);
    check("rst_pixels", 32'({px_upper, px_lower}), 32'd0);
    check("rst_latch", 32'(col_latch), 32'd0);
    check("rst_active_buf", 32'(active_buf), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);

    // Release with enable: first fetch one cycle out of IDLE.
    enable = 1'b1;
    push_frame(1'b0);
    push_frame(1'b0);
    #2 rst = 1'b1;
    @(negedge clk);
    check("first_fetch_en", 32'(fb_rd_en), 32'd1);
    check("first_fetch_addr", 32'(fb_rd_addr), 32'd0);

    // Buffer swap requested in the middle of frame 1.
    wait_frames(1);
    wait_cycles(20);
    use_sec = 1'b1;
    push_frame(1'b1);
    wait_cycles(5);
    check("active_buf_mid_frame", 32'(active_buf), 32'd0);
    check("addr_msb_mid_frame", 32'(fb_rd_addr[AW-1]), 32'd0);
    wait_frames(2);
    wait_cycles(2);
    check("active_buf_after_swap", 32'(active_buf), 32'd1);

    // Disable mid-frame: frame 2 completes, then idle.
    wait_cycles(50);
    enable = 1'b0;
    wait_frames(3);
    check("total_latches_3_frames", total_latches, 12);
    wait_cycles(90);
    check_idle("disable");

    // Reset in the middle of a shift.
    enable = 1'b1;
    push_frame(1'b1);
    budget = 500;
    while (!(pclk && pix_seen >= 30) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("reach_clk_hi_timeout", 32'(budget > 0), 32'd1);
    check("in_clk_hi", 32'(dbg_state), 32'(ST_CLK_HI));
    #2 rst = 1'b0;
    #1;
    check("async_rst_pixel_clk", 32'(pclk), 32'd0);
    check("async_rst_blank", 32'(blank), 32'd1);
    check("async_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    clear_queues();
    use_sec = 1'b0;
    first_pix = 1'b1;
    push_frame(1'b0);
    wait_cycles(3);
    #2 rst = 1'b1;
    @(negedge clk);
    check("restart_fetch_en", 32'(fb_rd_en), 32'd1);
    check("restart_fetch_addr", 32'(fb_rd_addr), 32'd0);
    wait_cycles(30);
    enable = 1'b0;
    wait_frames(4);
    wait_cycles(90);
    check_idle("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop if the scan never finishes.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
